// File: rtl/cache_pkg.sv
// Shared types and sizing for the cache arbiter: FSM state encoding, bus widths, default watchdog limit.
package cache_pkg;

    localparam int ADDR_W          = 32;
    localparam int LINE_W          = 512;
    localparam int DEFAULT_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-requester round-robin: when both request, the port that was not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_idx,
    output logic       gnt_valid
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        case (req)
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cache_arbiter.sv
// Two-port round-robin arbiter and transaction sequencer in front of the cache, with a watchdog that
// aborts hung transactions and saturating hit/miss statistics.
module cache_arbiter
    import cache_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p1_req,
    input  logic              p0_write,
    input  logic              p1_write,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [LINE_W-1:0] p0_wdata,
    input  logic [LINE_W-1:0] p1_wdata,
    output logic              p0_ack,
    output logic              p1_ack,
    output logic              p0_err,
    output logic              p1_err,
    output logic [LINE_W-1:0] p0_rdata,
    output logic [LINE_W-1:0] p1_rdata,
    output logic              bgn,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] address,
    output logic [LINE_W-1:0] data,
    input  logic [LINE_W-1:0] cache_outbus,
    input  logic              cache_hit,
    input  logic              cache_done,
    output logic              busy,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int WDOG_W = $clog2(TIMEOUT);

    state_e              state_q, state_d;
    logic                last_q, last_d;
    logic                grant_q, grant_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                err_q, err_d;
    logic [LINE_W-1:0]   p0_rdata_q, p0_rdata_d;
    logic [LINE_W-1:0]   p1_rdata_q, p1_rdata_d;
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

    logic arb_idx;
    logic arb_valid;

    rr_arb2 u_rr_arb2 (
        .req       ({p1_req, p0_req}),
        .last      (last_q),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    always_comb begin
        // NOTE: every _d starts at its held value so no branch can leave one unassigned and infer a latch.
        state_d    = state_q;
        last_d     = last_q;
        grant_d    = grant_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wdog_d     = wdog_q;
        err_d      = err_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_idx;
                    wr_d    = arb_idx ? p1_write : p0_write;
                    addr_d  = arb_idx ? p1_addr  : p0_addr;
                    wdata_d = arb_idx ? p1_wdata : p0_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Completion is checked before expiry so a done on the last allowed cycle still succeeds.
                if (cache_done) begin
                    err_d = 1'b0;
                    if (!wr_q) begin
                        if (grant_q) p1_rdata_d = cache_outbus;
                        else         p0_rdata_d = cache_outbus;
                    end
                    if (cache_hit) begin
                        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    end else begin
                        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    end
                    state_d = RESP;
                end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            RESP: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the line-wide rdata registers are reset along with control state because rdata must read 0 out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            grant_q    <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wdog_q     <= '0;
            err_q      <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            grant_q    <= grant_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wdog_q     <= wdog_d;
            err_q      <= err_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Cache controls decode straight from state so they fall the instant reset asserts.
    assign busy     = (state_q != IDLE);
    assign bgn      = (state_q == ISSUE);
    assign read     = busy & ~wr_q;
    assign write    = busy &  wr_q;
    assign address  = addr_q;
    assign data     = wdata_q;
    assign p0_ack   = (state_q == RESP) & ~grant_q;
    assign p1_ack   = (state_q == RESP) &  grant_q;
    assign p0_err   = p0_ack & err_q;
    assign p1_err   = p1_ack & err_q;
    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: directed transactions push expected acks; a negedge monitor pops and compares.
module tb_cache_arbiter;

    localparam int TO   = 8;
    localparam int CW   = 2;
    localparam int CMAX = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         p0_req, p1_req, p0_write, p1_write;
    logic [31:0]  p0_addr, p1_addr;
    logic [511:0] p0_wdata, p1_wdata;
    logic         p0_ack, p1_ack, p0_err, p1_err;
    logic [511:0] p0_rdata, p1_rdata;
    logic         bgn, read, write, busy;
    logic [31:0]  address;
    logic [511:0] data, cache_outbus;
    logic         cache_hit, cache_done;
    logic [CW-1:0] hit_cnt, miss_cnt;

    cache_arbiter #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p1_req(p1_req),
        .p0_write(p0_write), .p1_write(p1_write),
        .p0_addr(p0_addr), .p1_addr(p1_addr),
        .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
        .p0_ack(p0_ack), .p1_ack(p1_ack),
        .p0_err(p0_err), .p1_err(p1_err),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .bgn(bgn), .read(read), .write(write),
        .address(address), .data(data),
        .cache_outbus(cache_outbus), .cache_hit(cache_hit), .cache_done(cache_done),
        .busy(busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit           port;
        bit           err;
        logic [511:0] rdata;
        int           hit;
        int           miss;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [511:0] m_rdata [2];
    int           m_hit, m_miss;
    bit           r_write [2];
    logic [31:0]  r_addr  [2];
    logic [511:0] r_wdata [2];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit port, input bit err, input logic [511:0] rd, input int at);
        exp_t e;
        e.port  = port;
        e.err   = err;
        e.rdata = rd;
        e.hit   = m_hit;
        e.miss  = m_miss;
        e.cyc   = at;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input bit port, input bit wr, input logic [31:0] a, input logic [511:0] d);
        r_write[port] = wr;
        r_addr[port]  = a;
        r_wdata[port] = d;
        if (port) begin
            p1_write = wr; p1_addr = a; p1_wdata = d; p1_req = 1'b1;
        end else begin
            p0_write = wr; p0_addr = a; p0_wdata = d; p0_req = 1'b1;
        end
    endtask

    task automatic wait_ack(input bit port);
        int k = 0;
        while (k < 40 && !(port ? p1_ack : p0_ack)) begin
            tick();
            k++;
        end
        check("ack_seen", 512'(port ? p1_ack : p0_ack), 512'd1);
        if (port) p1_req = 1'b0;
        else      p0_req = 1'b0;
    endtask

    // Serves one granted transaction: expects `port` to win, completes it `dly` cycles after bgn
    // (or lets the watchdog expire), optionally pulsing a stray done during ISSUE.
    task automatic serve(input bit port, input int dly, input bit hit, input logic [511:0] ob,
                         input bit abort, input bit stray, output int b);
        int k = 0;
        b = -1;
        while (k < 40 && !bgn) begin
            tick();
            k++;
        end
        check("bgn_seen", 512'(bgn), 512'd1);
        if (!bgn) return;
        b = cyc;
        check("issue_addr",  512'(address), 512'(r_addr[port]));
        check("issue_data",  data, r_wdata[port]);
        check("issue_write", 512'(write), 512'(r_write[port]));
        check("issue_read",  512'(read), 512'(!r_write[port]));
        k = 0;
        if (stray) begin
            cache_done = 1'b1; cache_hit = 1'b1; cache_outbus = {16{32'hDEAD_BEEF}};
            tick();
            cache_done = 1'b0;
            k = 1;
        end
        if (abort) begin
            push(port, 1'b1, m_rdata[port], b + TO + 1);
        end else begin
            while (k < dly) begin
                tick();
                k++;
            end
            cache_done = 1'b1; cache_hit = hit; cache_outbus = ob;
            if (!r_write[port]) m_rdata[port] = ob;
            if (hit) m_hit  = (m_hit  < CMAX) ? m_hit + 1  : CMAX;
            else     m_miss = (m_miss < CMAX) ? m_miss + 1 : CMAX;
            push(port, 1'b0, m_rdata[port], cyc + 1);
            tick();
            cache_done = 1'b0; cache_outbus = '0;
        end
        wait_ack(port);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (busy) check("rw_onehot", 512'(int'(read) + int'(write)), 512'd1);
            else      check("rw_idle", 512'({read, write}), 512'd0);
            if (p0_ack || p1_ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 512'({p1_ack, p0_ack}), 512'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ack_vec",   512'({p1_ack, p0_ack}), mon_e.port ? 512'd2 : 512'd1);
                    check("ack_cycle", 512'(cyc), 512'(mon_e.cyc));
                    check("ack_err",   512'(mon_e.port ? p1_err : p0_err), 512'(mon_e.err));
                    check("ack_rdata", mon_e.port ? p1_rdata : p0_rdata, mon_e.rdata);
                    check("ack_hit",   512'(hit_cnt), 512'(mon_e.hit));
                    check("ack_miss",  512'(miss_cnt), 512'(mon_e.miss));
                end
            end
        end
    end

    initial begin
        int b;
        int n0;
        logic [511:0] p1_keep;

        rst = 1'b0;
        p0_req = 0; p1_req = 0; p0_write = 0; p1_write = 0;
        p0_addr = 0; p1_addr = 0; p0_wdata = 0; p1_wdata = 0;
        cache_outbus = 0; cache_hit = 0; cache_done = 0;
        m_rdata[0] = '0; m_rdata[1] = '0; m_hit = 0; m_miss = 0;

        // Reset held with both requesting: nothing may move
        set_req(0, 1'b0, 32'h0000_0100, {16{32'h1111_1111}});
        set_req(1, 1'b1, 32'h0000_0200, {16{32'h2222_2222}});
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_bgn",   512'(bgn), 512'd0);
            check("rst_busy",  512'(busy), 512'd0);
            check("rst_rw",    512'({read, write}), 512'd0);
            check("rst_ack",   512'({p1_ack, p0_ack, p1_err, p0_err}), 512'd0);
            check("rst_rdata", p0_rdata | p1_rdata, 512'd0);
            check("rst_cnt",   512'({hit_cnt, miss_cnt}), 512'd0);
            check("rst_bus",   data | 512'(address), 512'd0);
        end
        p0_req = 0; p1_req = 0;
        rst = 1'b1;
        repeat (3) tick();
        check("idle_busy", 512'(busy), 512'd0);
        check("idle_bgn",  512'(bgn), 512'd0);

        // Contention after reset: port 0 first, port 1 stays pending and follows
        set_req(0, 1'b0, 32'h0000_2000, {16{32'h0A0A_0A0A}});
        set_req(1, 1'b0, 32'h0000_3000, {16{32'h0B0B_0B0B}});
        serve(0, 2, 1'b1, {16{32'h1234_5678}}, 1'b0, 1'b0, b);
        serve(1, 1, 1'b0, {16{32'h8765_4321}}, 1'b0, 1'b0, b);

        // Single read with hand-timed latency: bgn at n0+1, done at n0+4, ack at n0+5
        tick();
        set_req(0, 1'b0, 32'h0000_1040, {16{32'h5555_AAAA}});
        n0 = cyc;
        serve(0, 3, 1'b1, {64{8'hA5}}, 1'b0, 1'b0, b);
        check("single_bgn_cycle", 512'(b), 512'(n0 + 1));
        check("single_rdata", p0_rdata, {64{8'hA5}});

        // Second contention: port 0 was served last, so port 1 (a write) goes first
        tick();
        p1_keep = p1_rdata;
        set_req(0, 1'b0, 32'h0000_4000, {16{32'h0C0C_0C0C}});
        set_req(1, 1'b1, 32'h0000_5000, {16{32'hFEED_F00D}});
        serve(1, 2, 1'b1, {16{32'hBAD0_BAD0}}, 1'b0, 1'b0, b);
        check("write_keeps_rdata", p1_rdata, p1_keep);
        serve(0, 1, 1'b0, {16{32'h0F0F_F0F0}}, 1'b0, 1'b0, b);

        // Watchdog abort: ack with err at n0+2+TIMEOUT, then a normal transaction
        tick();
        set_req(0, 1'b0, 32'h0000_6000, {16{32'h0D0D_0D0D}});
        n0 = cyc;
        serve(0, 0, 1'b0, '0, 1'b1, 1'b0, b);
        check("abort_ack_cycle", 512'(cyc), 512'(n0 + 2 + TO));
        tick();
        set_req(1, 1'b0, 32'h0000_7000, {16{32'h0E0E_0E0E}});
        serve(1, 1, 1'b1, {16{32'h7777_0000}}, 1'b0, 1'b0, b);

        // Done on the last WAIT cycle wins over expiry
        tick();
        set_req(0, 1'b0, 32'h0000_8000, {16{32'h1010_1010}});
        serve(0, TO, 1'b1, {16{32'hC0DE_C0DE}}, 1'b0, 1'b0, b);

        // Stray done in IDLE, then one during ISSUE
        tick();
        cache_done = 1'b1; cache_hit = 1'b0; cache_outbus = {16{32'hDEAD_DEAD}};
        tick();
        cache_done = 1'b0;
        check("stray_idle_busy", 512'(busy), 512'd0);
        check("stray_idle_cnt",  512'({hit_cnt, miss_cnt}), 512'({CW'(m_hit), CW'(m_miss)}));
        check("stray_idle_rd0",  p0_rdata, m_rdata[0]);
        set_req(1, 1'b0, 32'h0000_9000, {16{32'h2020_2020}});
        serve(1, 3, 1'b0, {16{32'h3C3C_3C3C}}, 1'b0, 1'b1, b);

        // Reset asserted during WAIT: transaction dropped, no ack
        tick();
        set_req(0, 1'b0, 32'h0000_A000, {16{32'h3030_3030}});
        repeat (3) tick();
        check("pre_rst_busy", 512'(busy), 512'd1);
        #1 rst = 1'b0;
        #1;
        check("wait_rst_ctl",   512'({bgn, read, write, busy}), 512'd0);
        check("wait_rst_ack",   512'({p1_ack, p0_ack}), 512'd0);
        check("wait_rst_rdata", p0_rdata | p1_rdata, 512'd0);
        check("wait_rst_cnt",   512'({hit_cnt, miss_cnt}), 512'd0);
        p0_req = 1'b0;
        tick();
        rst = 1'b1;
        m_rdata[0] = '0; m_rdata[1] = '0; m_hit = 0; m_miss = 0;
        repeat (4) tick();
        check("post_rst_busy", 512'(busy), 512'd0);

        // Saturation: five misses leave a 2-bit counter at 3
        for (int i = 0; i < 5; i++) begin
            tick();
            set_req(0, 1'b0, 32'h0000_B000 + 32'(i * 64), {16{32'h4040_4040}});
            serve(0, 1 + i, 1'b0, {16{32'h5000_0000 + 32'(i)}}, 1'b0, 1'b0, b);
        end
        repeat (2) tick();
        check("miss_saturated", 512'(miss_cnt), 512'd3);
        check("hit_after_sat",  512'(hit_cnt), 512'd0);
        check("queue_drained",  512'(exp_q.size()), 512'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-port request arbiter and transaction sequencer in front of the cache top (`modules`). Accepts independent read/write requests from two requesters, grants one at a time round-robin, and drives the cache's `bgn`/`read`/`write`/`address`/`data` for the granted transaction. It holds those inputs stable until the cache signals completion, then returns read data and a one-cycle acknowledge to the winner. A watchdog aborts hung transactions, and hit/miss statistics are kept.

## Interface
- `TIMEOUT`, 64: maximum cycles spent in WAIT before abort; must be ≥2.
- `CNT_W`, 16: width of saturating hit/miss counters.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `p0_req`, `p1_req`  in  1  level request; held until matching ack.
- `p0_write`, `p1_write`  in  1  1 = write, 0 = read; stable while req.
- `p0_addr`, `p1_addr`  in  32  address; stable while req.
- `p0_wdata`, `p1_wdata`  in  512  write data; stable while req.
- `p0_ack`, `p1_ack`  out  1  one-cycle completion pulse.
- `p0_err`, `p1_err`  out  1  valid with ack; 1 = watchdog abort.
- `p0_rdata`, `p1_rdata`  out  512  read result; valid from ack until that port's next ack.
- `bgn`  out  1  one-cycle start pulse to cache.
- `read`, `write`  out  1  operation select to cache; one-hot while busy, both 0 in IDLE.
- `address`  out  32  to cache.
- `data`  out  512  to cache.
- `cache_outbus`  in  512  cache read data.
- `cache_hit`  in  1  cache hit indication, sampled with `cache_done`.
- `cache_done`  in  1  one-cycle pulse: transaction complete, `cache_outbus` valid.
- `busy`  out  1  state ≠ IDLE.
- `hit_cnt`, `miss_cnt`  out  CNT_W  saturating counters of completed transactions.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req, pick winner via round-robin; latch winner's write/addr/wdata into internal registers, record grant index; → ISSUE. No req → stay.
- Round-robin: `last` register holds last-served port. Both requesting → grant port ≠ `last`. Single requester always wins. Reset `last`=1, so port 0 wins first contention.
- ISSUE: `bgn`=1 for exactly this cycle; `read`/`write`/`address`/`data` driven from latched registers; watchdog cleared; → WAIT.
- WAIT: cache inputs held stable, `bgn`=0. On `cache_done`: capture `cache_outbus` into granted port's rdata (reads only; writes leave rdata unchanged), increment hit_cnt or miss_cnt per `cache_hit`, err=0, → RESP. If watchdog reaches TIMEOUT−1 without done: err=1, rdata unchanged, counters unchanged, → RESP.
- RESP: granted port's ack=1 (and err as captured); `last` ← grant; `read`/`write` ← 0; → IDLE.
- Counters saturate at 2^CNT_W−1; no wrap.
- Loser's request stays pending untouched; it is served next.

## Timing
- Reset (async assert, sync deassert by the surrounding design): state IDLE, `last`=1, all outputs 0 including rdata, counters and watchdog.
- Reset mid-transaction: transaction dropped, no ack issued, `bgn`/`read`/`write` drop immediately.
- Latency: req sampled high in IDLE at cycle 0 → `bgn` cycle 1 → earliest `cache_done` cycle 2 → ack cycle 3. In general ack = done cycle + 1.
- Requester deasserts req on the edge where it samples ack=1. A req still high in the following IDLE cycle is a new request.
- `cache_done` outside WAIT is ignored.
- `cache_done` and watchdog expiry in the same cycle: done wins, err=0.
- WAIT lasts at most TIMEOUT cycles. Abort ack occurs at cycle 2+TIMEOUT after the request.
- Back-to-back throughput: one transaction per (done latency + 2) cycles. IDLE always occupies ≥1 cycle between transactions.

## Structure
- Shared package `cache_pkg`: state enum (IDLE/ISSUE/WAIT/RESP), address/line width constants (32, 512), default TIMEOUT.
- One sub-module: `rr_arb2`, combinational two-requester round-robin grant from (`req[1:0]`, `last`), giving grant index and valid.
- FSM, latches, watchdog and counters live in `cache_arbiter`.

## Test plan
- Reset: hold `rst`=0, drive reqs → all outputs 0, `bgn` never asserted. Release with no req → stays IDLE, `busy`=0.
- Single read: p0 read addr 0x0000_1040; cache returns done at cycle 4 with outbus=0xA5…A5, hit=1 → `bgn` cycle 1, p0_ack/p0_rdata=0xA5…A5 cycle 5, err=0, hit_cnt=1.
- Contention: p0 and p1 both req at cycle 0 → p0 served first, then p1. Repeat with both req → p1 first (alternation confirmed). p1 write leaves p1_rdata unchanged.
- Watchdog: TIMEOUT=8, never pulse done → p0_ack with p0_err=1 at cycle 10; counters unchanged; next request proceeds normally.
- Boundary: done coincident with watchdog expiry → err=0, data captured. Stray `cache_done` in IDLE/ISSUE → no effect. Assert reset during WAIT → no ack, outputs 0.
- Saturation: CNT_W=2, five misses → miss_cnt stays 3.
